fire_dec: RTL

- Serial Fire-code decoder with burst correction. It is the receive-side counterpart of the p(x) remainder register used by the encoder.
- Takes an N-bit shortened codeword and computes two syndromes serially: s_c = r mod (x^C+1) and s_p = r mod p(x), with p(x)=x^9+x^4+1.
- Traps the error burst, locates it, and outputs the corrected word with status flags.
- Sits after the channel/storage model and before the payload consumer.

---
 rtl/fire_pkg.sv | 40 ++++
 rtl/fire_p_lfsr.sv | 33 +++
 rtl/fire_dec.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fire_pkg.sv
// Shared constants, state/mode enums and helpers for the serial Fire-code decoder.
// Default build has no statistics; define FIRE_DEC_STATS_EN to add them.
package fire_pkg;

    localparam int N   = 64;
    localparam int K   = 40;
    localparam int C   = 15;
    localparam int M   = 9;
    localparam int L   = 8;
    localparam int CW  = 11;
    localparam int NW  = $clog2(N);
    localparam int CPW = $clog2(C);

    localparam logic [M-1:0] P_TAPS = 9'b000010001;

    typedef enum logic [2:0] {
        IDLE,
        SYND,
        CHECK,
        TRAP,
        LOCATE,
        FIN
    } state_t;

    typedef enum logic [1:0] {
        LF_HOLD,
        LF_LOAD,
        LF_SHIFT,
        LF_MULX
    } lf_mode_t;

    // Index of the highest set bit of a burst pattern (0 for an all-zero pattern).
    function automatic logic [CW-1:0] msb_idx(input logic [L-1:0] b);
        msb_idx = '0;
        for (int n = 0; n < L; n++) begin
            if (b[n]) msb_idx = CW'(n);
        end
    endfunction

endpackage

// File: rtl/fire_p_lfsr.sv
// M-bit remainder register modulo p(x): hold, parallel load, shift in one
// received bit (MSB first), or multiply the contents by x.
module fire_p_lfsr
    import fire_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  lf_mode_t     mode,
    input  logic [M-1:0] load_val,
    input  logic         bit_in,
    output logic [M-1:0] q
);

    logic [M-1:0] times_x;

    always_comb begin
        times_x = {q[M-2:0], 1'b0} ^ (q[M-1] ? P_TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            case (mode)
                LF_LOAD:  q <= load_val;
                LF_SHIFT: q <= times_x ^ {{(M-1){1'b0}}, bit_in};
                LF_MULX:  q <= times_x;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/fire_dec.sv
// Serial Fire-code decoder: syndromes, burst trapping in s_c, location via p(x) search.
// Optional FIRE_DEC_STATS_EN adds saturating corrected/uncorrectable counters.
module fire_dec
    import fire_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  data_in,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  data_out,
    output logic          corrected,
    output logic          uncorrectable,
    output logic [CW-1:0] err_pos,
    output logic [L-1:0]  burst,
    output logic [CW-1:0] count
`ifdef FIRE_DEC_STATS_EN
    ,
    output logic [15:0]   n_corr,
    output logic [15:0]   n_uncorr
`endif
);

    state_t         state, state_nxt;
    logic [N-1:0]   word;
    logic [C-1:0]   s_c;
    logic [M-1:0]   s_p, t;
    logic [L-1:0]   b_reg;
    logic [CPW-1:0] j, ph;
    lf_mode_t       sp_mode, t_mode;
    logic [NW-1:0]  r_idx;
    logic           r_bit, trap_hit, match, in_range;

    fire_p_lfsr u_sp (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (sp_mode),
        .load_val ('0),
        .bit_in   (r_bit),
        .q        (s_p)
    );

    fire_p_lfsr u_t (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (t_mode),
        .load_val ({{(M-L){1'b0}}, s_c[L-1:0]}),
        .bit_in   (1'b0),
        .q        (t)
    );

    always_comb begin
        r_idx    = NW'(N-1) - count[NW-1:0];
        r_bit    = word[r_idx];
        trap_hit = (s_c[C-1:L] == '0) && s_c[0];
        match    = (ph == j) && (t == s_p);
        in_range = (count + msb_idx(b_reg)) <= CW'(N-1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sp_mode   = LF_HOLD;
        t_mode    = LF_HOLD;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SYND;
                    sp_mode   = LF_LOAD;
                end
            end
            SYND: begin
                sp_mode = LF_SHIFT;
                if (count == CW'(N-1)) state_nxt = CHECK;
            end
            CHECK: begin
                if ((s_c == '0) || (s_p == '0)) state_nxt = FIN;
                else                            state_nxt = TRAP;
            end
            TRAP: begin
                if (trap_hit) begin
                    state_nxt = LOCATE;
                    t_mode    = LF_LOAD;
                end else if (count == CW'(C-1)) begin
                    state_nxt = FIN;
                end
            end
            LOCATE: begin
                if (match || (count == CW'(N-1))) state_nxt = FIN;
                else                              t_mode    = LF_MULX;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // count doubles as bit index in SYND, rotation k in TRAP and position i in LOCATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            data_out      <= '0;
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            err_pos       <= '0;
            burst         <= '0;
            count         <= '0;
            word          <= '0;
            s_c           <= '0;
            b_reg         <= '0;
            j             <= '0;
            ph            <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word          <= data_in;
                        s_c           <= '0;
                        count         <= '0;
                        busy          <= 1'b1;
                        data_out      <= '0;
                        corrected     <= 1'b0;
                        uncorrectable <= 1'b0;
                        err_pos       <= '0;
                        burst         <= '0;
                    end
                end
                SYND: begin
                    s_c   <= {s_c[C-2:0], s_c[C-1]} ^ {{(C-1){1'b0}}, r_bit};
                    count <= count + 1'b1;
                end
                CHECK: begin
                    count    <= '0;
                    data_out <= word;
                    if ((s_c != '0) != (s_p != '0)) uncorrectable <= 1'b1;
                end
                TRAP: begin
                    if (trap_hit) begin
                        b_reg <= s_c[L-1:0];
                        j     <= count[CPW-1:0];
                        count <= '0;
                        ph    <= '0;
                    end else begin
                        s_c   <= {s_c[0], s_c[C-1:1]};
                        count <= count + 1'b1;
                        if (count == CW'(C-1)) uncorrectable <= 1'b1;
                    end
                end
                LOCATE: begin
                    if (match) begin
                        if (in_range) begin
                            data_out  <= word ^ ({{(N-L){1'b0}}, b_reg} << count);
                            corrected <= 1'b1;
                            err_pos   <= count;
                            burst     <= b_reg;
                        end else begin
                            uncorrectable <= 1'b1;
                        end
                    end else if (count == CW'(N-1)) begin
                        uncorrectable <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                        ph    <= (ph == CPW'(C-1)) ? '0 : ph + 1'b1;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef FIRE_DEC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_corr   <= '0;
            n_uncorr <= '0;
        end else if (state == FIN) begin
            if (corrected && (n_corr != '1))         n_corr   <= n_corr + 1'b1;
            if (uncorrectable && (n_uncorr != '1))   n_uncorr <= n_uncorr + 1'b1;
        end
    end
`endif

endmodule
